dff_reg_file: RTL

//   Parametrised bank of DEPTH load-enabled D registers, each WIDTH bits wide.
//   One synchronous write port and two registered read ports (A, B).
//   It is the general-purpose register file for the processor datapath and

---
 rtl/dff_reg_file_if.sv | 27 ++
 rtl/dff_reg_file.sv | 102 ++++++++++
 2 files changed

// File: rtl/dff_reg_file_if.sv
// Bus bundle for dff_reg_file: write port, shared read request, two read
// ports and the read-valid flag. The master side drives requests and write
// data; the slave side (the register file) returns read data.
interface dff_reg_file_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              load;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  D;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  Q_a;
  logic [WIDTH-1:0]  Q_b;
  logic              q_valid;

  modport master (
    output load, waddr, D, rd_en, raddr_a, raddr_b,
    input  Q_a, Q_b, q_valid
  );

  modport slave (
    input  load, waddr, D, rd_en, raddr_a, raddr_b,
    output Q_a, Q_b, q_valid
  );
endinterface

// File: rtl/dff_reg_file.sv
// dff_reg_file: DEPTH x WIDTH general-purpose register file with one
// synchronous write port and two registered read ports sharing one request.
// Read data appears one cycle after the request, flagged by q_valid.
// Same-address read/write on one edge returns the old value, unless the
// macro DFF_REG_FILE_BYPASS_EN is defined, which adds write-first bypass.
// Out-of-range addresses read as zero and drop writes; with ZERO_REG=1,
// register 0 always reads zero and ignores writes.
module dff_reg_file #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0
) (
  input  logic          clock,
  input  logic          clear,
  dff_reg_file_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam bit ZR     = (ZERO_REG != 0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q_a;
  logic [WIDTH-1:0] r_q_b;
  logic             r_vld;

  logic             w_wa_ok;
  logic             w_ra_ok;
  logic             w_rb_ok;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // Address range checks collapse to constants when DEPTH fills the address space
  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign w_wa_ok = 1'b1;
    assign w_ra_ok = 1'b1;
    assign w_rb_ok = 1'b1;
  end else begin : g_part
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    assign w_wa_ok = ({1'b0, bus.waddr}   < DEPTH_W);
    assign w_ra_ok = ({1'b0, bus.raddr_a} < DEPTH_W);
    assign w_rb_ok = ({1'b0, bus.raddr_b} < DEPTH_W);
  end

  // A write only takes effect when enabled, in range and not aimed at a hard-wired zero
  assign w_wr_ok = bus.load & w_wa_ok & ~(ZR & (bus.waddr == '0));

  // Port A read word: zero for unmapped or hard-wired addresses, optional write-first bypass
  always_comb begin
    w_rd_a = '0;
    if (w_ra_ok && !(ZR && (bus.raddr_a == '0))) begin
      w_rd_a = r_mem[bus.raddr_a];
    end
`ifdef DFF_REG_FILE_BYPASS_EN
    if (w_wr_ok && (bus.raddr_a == bus.waddr)) begin
      w_rd_a = bus.D;
    end
`endif
  end

  // Port B read word: same selection rules as port A
  always_comb begin
    w_rd_b = '0;
    if (w_rb_ok && !(ZR && (bus.raddr_b == '0))) begin
      w_rd_b = r_mem[bus.raddr_b];
    end
`ifdef DFF_REG_FILE_BYPASS_EN
    if (w_wr_ok && (bus.raddr_b == bus.waddr)) begin
      w_rd_b = bus.D;
    end
`endif
  end

  // Register array: cleared asynchronously, written on the rising edge
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[bus.waddr] <= bus.D;
    end
  end

  // Read stage: capture both ports on request, otherwise hold data and drop valid
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_q_a <= '0;
      r_q_b <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= bus.rd_en;
      if (bus.rd_en) begin
        r_q_a <= w_rd_a;
        r_q_b <= w_rd_b;
      end
    end
  end

  assign bus.Q_a     = r_q_a;
  assign bus.Q_b     = r_q_b;
  assign bus.q_valid = r_vld;
endmodule
